// File: rtl/pixel_gen_pal.sv
// Pixel generator for the Mandelbrot display path.
// Turns VGA scan coordinates into a frame-buffer read address, takes the
// returned iteration count and runs it through a selectable palette that can
// rotate once per frame. Pipeline depth from coordinate to colour is RD_LAT+2.
module pixel_gen_pal #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ITER_W = 7,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic              CLK_100MHz,
  input  logic              reset,
  input  logic              video_on,
  input  logic              read_enable,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic [1:0]        mode,
  input  logic              rotate_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [ITER_W-1:0] rd_data,
  output logic [11:0]       color,
  output logic              frame_done,
  output logic [18:0]       pixel_count
);

  localparam logic [10:0]       HRES_C   = 11'(H_RES);
  localparam logic [10:0]       VRES_C   = 11'(V_RES);
  localparam logic [9:0]        X_LAST   = 10'(H_RES - 1);
  localparam logic [9:0]        Y_LAST   = 10'(V_RES - 1);
  localparam logic [ADDR_W-1:0] HRES_A   = ADDR_W'(H_RES);
  localparam logic [ITER_W-1:0] ITER_MAX = '1;
  localparam logic [18:0]       CNT_MAX  = '1;

  // stage 0
  logic              in_range;
  logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic              s0_valid_d, s0_valid_q;
  logic              s0_last_d, s0_last_q;
  logic [1:0]        s0_mode_q;

  // delay line matching the BRAM read latency
  logic [RD_LAT-1:0]      dl_valid_q;
  logic [RD_LAT-1:0]      dl_last_q;
  logic [RD_LAT-1:0][1:0] dl_mode_q;
  logic                   p_valid, p_last;
  logic [1:0]             p_mode;

  // stage 2 / palette
  logic [ITER_W-1:0] offset_d, offset_q;
  logic [ITER_W-1:0] idx;
  logic [3:0]        h;
  logic [1:0]        band;
  logic [11:0]       pal;
  logic [11:0]       color_d, color_q;
  logic              frame_done_q;
  logic              out_valid_q;
  logic [18:0]       pixel_count_q;

  // Address, qualification and last-pixel decode of the incoming coordinate.
  always_comb begin
    in_range   = ({1'b0, pixel_x} < HRES_C) && ({1'b0, pixel_y} < VRES_C);
    rd_addr_d  = '0;
    if (in_range) rd_addr_d = ADDR_W'(pixel_y) * HRES_A + ADDR_W'(pixel_x);
    s0_valid_d = video_on & read_enable & in_range;
    s0_last_d  = (pixel_x == X_LAST) && (pixel_y == Y_LAST);
  end

  // Stage 0 registers: read address goes straight to the BRAM.
  always_ff @(posedge CLK_100MHz or negedge reset) begin
    if (!reset) begin
      rd_addr_q  <= '0;
      s0_valid_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_mode_q  <= 2'd0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      s0_valid_q <= s0_valid_d;
      s0_last_q  <= s0_last_d;
      s0_mode_q  <= mode;
    end
  end

  // Carry per-pixel attributes alongside the read so they meet rd_data.
  always_ff @(posedge CLK_100MHz or negedge reset) begin
    if (!reset) begin
      dl_valid_q <= '0;
      dl_last_q  <= '0;
      dl_mode_q  <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_last_q[i]  <= dl_last_q[i-1];
        dl_mode_q[i]  <= dl_mode_q[i-1];
      end
      dl_valid_q[0] <= s0_valid_q;
      dl_last_q[0]  <= s0_last_q;
      dl_mode_q[0]  <= s0_mode_q;
    end
  end

  assign p_valid = dl_valid_q[RD_LAT-1];
  assign p_last  = dl_last_q[RD_LAT-1];
  assign p_mode  = dl_mode_q[RD_LAT-1];

  // Rotation steps while frame_done is shown; the bypass lets the very next
  // pixel already see the new offset.
  always_comb begin
    offset_d = offset_q;
    if (frame_done_q && rotate_en) offset_d = offset_q + ITER_W'(1);
  end

  // Palette lookup; the inside-set test uses the raw count, not the rotated index.
  always_comb begin
    idx  = rd_data + offset_d;
    h    = 4'(idx >> (ITER_W - 4));
    band = 2'(idx);
    pal  = 12'h000;
    case (p_mode)
      2'd0: pal = {h, h, h};
      2'd1: begin
        if (!h[3]) pal = {h[2:0], 1'b0, 8'h00};
        else       pal = {4'hF, h[2:0], 1'b0, 4'h0};
      end
      2'd2: begin
        case (band)
          2'd0:    pal = 12'hF00;
          2'd1:    pal = 12'h0F0;
          2'd2:    pal = 12'h00F;
          default: pal = 12'hFF0;
        endcase
      end
      default: pal = 12'(rd_data);
    endcase
    if ((rd_data == ITER_MAX) && (p_mode != 2'd3)) pal = 12'h000;
    color_d = p_valid ? pal : 12'h000;
  end

  // Stage 2 output registers.
  always_ff @(posedge CLK_100MHz or negedge reset) begin
    if (!reset) begin
      color_q      <= 12'h000;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      color_q      <= color_d;
      frame_done_q <= p_valid & p_last;
      out_valid_q  <= p_valid;
    end
  end

  // Count of visible pixels already shown this frame; cleared after the last.
  always_ff @(posedge CLK_100MHz or negedge reset) begin
    if (!reset) begin
      pixel_count_q <= '0;
    end else if (frame_done_q) begin
      pixel_count_q <= '0;
    end else if (out_valid_q && (pixel_count_q != CNT_MAX)) begin
      pixel_count_q <= pixel_count_q + 19'd1;
    end
  end

  // Palette rotation offset.
  always_ff @(posedge CLK_100MHz or negedge reset) begin
    if (!reset) offset_q <= '0;
    else        offset_q <= offset_d;
  end

  assign rd_addr     = rd_addr_q;
  assign color       = color_q;
  assign frame_done  = frame_done_q;
  assign pixel_count = pixel_count_q;

endmodule

// File: doc/pixel_gen_pal.md
Name: pixel_gen_pal

Overview:
- Parametrised successor pixel generator for the Mandelbrot display path.
- Converts VGA scan coordinates into a linear frame-buffer read address and drives an external dual-port BRAM read port (write port stays with the compute engine).
- Maps the returned iteration count through a selectable colour palette with per-frame palette rotation.
- Emits a pipeline-aligned 12-bit RGB colour plus frame bookkeeping (frame_done, pixel_count).

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines per frame.
- ITER_W, 7, iteration-count width; must be >= 4.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- RD_LAT, 1, external BRAM read latency in cycles; must be >= 1.

Ports:
- CLK_100MHz  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- video_on  in  1  visible-region flag from the VGA sync block.
- read_enable  in  1  frame buffer valid for display; 0 forces black.
- pixel_x  in  10  current scan column.
- pixel_y  in  10  current scan line.
- mode  in  2  palette select: 0 gray, 1 fire, 2 banded, 3 raw.
- rotate_en  in  1  enables per-frame palette rotation.
- rd_addr  out  ADDR_W  BRAM read address.
- rd_data  in  ITER_W  BRAM read data, valid RD_LAT cycles after rd_addr.
- color  out  12  {R[3:0],G[3:0],B[3:0]}.
- frame_done  out  1  one-cycle pulse coincident with the colour of the last visible pixel.
- pixel_count  out  19  visible pixels output so far in the current frame.

Behaviour:
- Reset (reset=0, asynchronous) clears all of the following to 0:
  - outputs: rd_addr, color, frame_done, pixel_count;
  - internal state: rotation offset and all pipeline registers.
- Total latency: LAT = RD_LAT + 2 cycles from a sampled (pixel_x, pixel_y) to its colour. The sync block delays hsync/vsync by LAT.
- Stage 0 (1 cycle) registers:
  - rd_addr = pixel_y*H_RES + pixel_x, computed at ADDR_W width.
  - valid = video_on & read_enable & in_range, where in_range = (pixel_x < H_RES) & (pixel_y < V_RES).
  - mode, plus last = (pixel_x == H_RES-1) & (pixel_y == V_RES-1).
  - When not in_range, rd_addr = 0.
- Delay line: valid/mode/last are delayed RD_LAT cycles alongside the BRAM read.
- Stage 2 (1 cycle) registers color, frame_done and pixel_count from rd_data.
- Palette index: idx = (rd_data + offset) mod 2^ITER_W; h = idx[ITER_W-1 -: 4].
- Inside-set rule: rd_data == 2^ITER_W-1 gives color = 12'h000 in modes 0-2.
- Mode 0 gray: color = {h,h,h}.
- Mode 1 fire:
  - h < 8: R = h<<1, G = 0.
  - h >= 8: R = 4'hF, G = (h-8)<<1.
  - B = 0 in both cases.
- Mode 2 banded: idx[1:0] selects 0 -> 12'hF00, 1 -> 12'h0F0, 2 -> 12'h00F, 3 -> 12'hFF0.
- Mode 3 raw: color = zero-extended rd_data; no rotation, no inside-set rule (legacy-compatible output).
- Invalid pixel (valid = 0): color = 12'h000, pixel_count holds.
- pixel_count:
  - Increments by 1 per valid output pixel.
  - On the cycle a valid output carries last = 1, frame_done = 1 and pixel_count loads 0 on the next edge.
  - Saturates at 2^19-1; never wraps mid-frame.
- frame_done is 0 on all other cycles.
- Rotation offset: incremented by 1 (mod 2^ITER_W) on the frame_done cycle when rotate_en = 1. Holds when rotate_en = 0. Takes effect from the next output pixel.
- Mode switching: mode is captured at stage 0 and travels with its pixel, so a mid-frame switch affects only pixels sampled after the change; no glitch on in-flight pixels.
- Reset mid-frame: pipeline flushes; the first LAT outputs after release are black (valid regs = 0); pixel_count restarts at 0.

Test Plan:
- Reset: hold reset = 0 with live inputs -> color = 000, rd_addr = 0, frame_done = 0, pixel_count = 0; release -> first non-black colour appears exactly RD_LAT+2 cycles after the first valid coordinate.
- Addressing: (x=5, y=2) -> rd_addr = 1285; (x=639, y=479) -> 307199; (x=700, y=10) -> rd_addr = 0 and color = 000.
- Palette, offset 0, ITER_W = 7:
  - rd_data = 0x40: mode 0 -> 888, mode 1 -> F00, mode 2 -> F00, mode 3 -> 040.
  - rd_data = 0x7F: modes 0-2 -> 000, mode 3 -> 07F.
- Gating: video_on = 0 or read_enable = 0 with rd_data = 0x10 -> color = 000 and pixel_count does not advance.
- Frame end: full 640x480 scan with all pixels valid -> single frame_done pulse aligned with pixel (639,479); pixel_count = 307199 on that cycle, 0 on the next.
- Rotation: rotate_en = 1, rd_data = 0x03, mode 2 -> frame 0 colour FF0, frame 1 F00 (offset = 1), frame 2 0F0; rotate_en = 0 -> offset holds.
